vga_capture: RTL

- Receive-side counterpart of the `vga` raster generator: samples `hsync`, `vsync`, `blank` and `rgb` in the system clock domain and writes each visible pixel into a frame memory.
- Used as a loopback checker for the `vga` output and as a frame grabber for the GPU path; replaces file dumping with an on-chip, self-checking capture.
- Captures exactly one frame per `arm` request and flags geometry errors.

---
 rtl/vga_capture.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/vga_capture.sv
// Frame grabber for a vga raster: writes one complete visible frame per arm into frame memory.
// Latency: a pixel reaches wr_en/wr_addr/wr_data 2 clocks after it appears on the inputs.
// Backpressure: none; the memory must accept one write per clock, and arm is dropped while busy.
module vga_capture #(
  parameter int H_ACTIVE     = 640,
  parameter int V_ACTIVE     = 480,
  parameter int ADDR_W       = 19,
  parameter bit SYNC_ACT_LOW = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              arm,
  input  logic              vga_clock,
  input  logic              hsync,
  input  logic              vsync,
  input  logic              blank,
  input  logic [23:0]       rgb,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [23:0]       wr_data,
  output logic              busy,
  output logic              frame_done,
  output logic              line_err,
  output logic              frame_err
);

  // h holds 0..H_ACTIVE; v holds 0..V_ACTIVE+1, where the extra value means the frame had too many lines
  localparam int H_W = $clog2(H_ACTIVE + 1);
  localparam int V_W = $clog2(V_ACTIVE + 2);

  localparam logic [H_W-1:0]    H_MAX  = H_W'(H_ACTIVE);
  localparam logic [V_W-1:0]    V_MAX  = V_W'(V_ACTIVE);
  localparam logic [V_W-1:0]    V_SAT  = V_W'(V_ACTIVE + 1);
  localparam logic [ADDR_W-1:0] H_STEP = ADDR_W'(H_ACTIVE);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SYNC    = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t state_q, state_d;

  // Registered raster inputs and one extra stage of blank / vs_act for edge detection.
  // Line ends are taken from blank's falling edge, so hsync carries no extra information here.
  logic        vclk_q;
  logic        blank_q, blank_d1;
  logic        vs_act_q, vs_act_d1;
  logic [23:0] rgb_q;

  logic [H_W-1:0]    h_q;
  logic [V_W-1:0]    v_q;
  logic [V_W-1:0]    v_inc;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] base_q;

  logic pix_evt, line_end, vs_rise;
  logic start_cap, do_write, line_adv, set_le, set_fe, clr_err;

  assign pix_evt  = ~vclk_q & blank_q;
  assign line_end = blank_d1 & ~blank_q;
  assign vs_rise  = vs_act_q & ~vs_act_d1;

  // v saturates one past V_ACTIVE so that an overlong frame stays distinguishable
  assign v_inc = (v_q == V_SAT) ? v_q : v_q + V_W'(1);

  assign busy       = (state_q == SYNC) || (state_q == CAPTURE);
  assign frame_done = (state_q == DONE);

  // Input register stage; vs_act is high while vsync is at its asserted level
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vclk_q    <= 1'b0;
      blank_q   <= 1'b0;
      blank_d1  <= 1'b0;
      vs_act_q  <= 1'b0;
      vs_act_d1 <= 1'b0;
      rgb_q     <= '0;
    end else begin
      vclk_q    <= vga_clock;
      blank_q   <= blank;
      blank_d1  <= blank_q;
      vs_act_q  <= vsync ^ SYNC_ACT_LOW;
      vs_act_d1 <= vs_act_q;
      rgb_q     <= rgb;
    end
  end

  // FSM state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state and per-cycle datapath controls
  always_comb begin
    state_d   = state_q;
    start_cap = 1'b0;
    do_write  = 1'b0;
    line_adv  = 1'b0;
    set_le    = 1'b0;
    set_fe    = 1'b0;
    clr_err   = 1'b0;
    case (state_q)
      IDLE: begin
        if (arm) begin
          state_d = SYNC;
          clr_err = 1'b1;
        end
      end
      SYNC: begin
        // anything before the first frame boundary belongs to a partial frame
        if (vs_rise) begin
          state_d   = CAPTURE;
          start_cap = 1'b1;
        end
      end
      CAPTURE: begin
        if (pix_evt) begin
          if ((h_q < H_MAX) && (v_q < V_MAX)) begin
            do_write = 1'b1;
          end else begin
            if (h_q >= H_MAX) set_le = 1'b1;
            if (v_q >= V_MAX) set_fe = 1'b1;
          end
        end
        if (line_end) begin
          line_adv = 1'b1;
          if (h_q != H_MAX) set_le = 1'b1;
        end
        // a line ending in the same cycle counts towards the frame before the check
        if (vs_rise) begin
          state_d = DONE;
          if ((line_end ? v_inc : v_q) != V_MAX) set_fe = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Column/line counters and address; each line restarts at base = v*H_ACTIVE
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      h_q    <= '0;
      v_q    <= '0;
      addr_q <= '0;
      base_q <= '0;
    end else if (start_cap) begin
      h_q    <= '0;
      v_q    <= '0;
      addr_q <= '0;
      base_q <= '0;
    end else if (do_write) begin
      h_q    <= h_q + H_W'(1);
      addr_q <= addr_q + ADDR_W'(1);
    end else if (line_adv) begin
      h_q <= '0;
      v_q <= v_inc;
      if (v_q != V_SAT) begin
        base_q <= base_q + H_STEP;
        addr_q <= base_q + H_STEP;
      end
    end
  end

  // Sticky geometry flags, cleared when a new capture is accepted
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      line_err  <= 1'b0;
      frame_err <= 1'b0;
    end else if (clr_err) begin
      line_err  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (set_le) line_err  <= 1'b1;
      if (set_fe) frame_err <= 1'b1;
    end
  end

  // Frame-memory write port
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= do_write;
      if (do_write) begin
        wr_addr <= addr_q;
        wr_data <= rgb_q;
      end
    end
  end

endmodule
